raster_frame_renderer: RTL
==========================

// Module: raster_frame_renderer
// PURPOSE
//  Sequential successor to the per-pixel colour box: walks the full screen in raster order and emits one RGB pixel per clock on a valid/ready stream.
//  Sits between game logic (doodle/block/camera state) and the display/framebuffer writer.
//  Supports rectangular blocks and doodle sprite, camera offset on all objects, and per-frame input snapshot (no tearing).
// PARAMETERS
//  SCREEN_W    400  pixels per line
//  SCREEN_H    700  lines per frame
//  NUM_BLOCKS  16   block slots tested in parallel
//  BLOCK_W     40   block width, pixels
//  BLOCK_H     5    block height, pixels
//  DOODLE_W    8    doodle sprite width
//  DOODLE_H    8    doodle sprite height
//  COORD_W     16   coordinate width, all x/y ports
//  GRID_STEP   50   grid pitch (RENDER_GRID_EN only)
// PORTS
//  clk           in   1                   clock
//  reset         in   1                   synchronous, active-high
//  start         in   1                   frame request, sampled in IDLE
//  game_over     in   1                   selects RED background
//  doodle_x      in   COORD_W             doodle left edge, world
//  doodle_y      in   COORD_W             doodle top edge, world
//  min_y         in   COORD_W             camera top, world
//  blocks_x      in   NUM_BLOCKS*COORD_W  block left edges, slot i at [i*COORD_W +: COORD_W]
//  blocks_y      in   NUM_BLOCKS*COORD_W  block top edges, world
//  block_active  in   NUM_BLOCKS          slot enable
//  pix_valid     out  1                   output pixel valid
//  pix_ready     in   1                   sink accepts
//  pix_x         out  COORD_W             pixel column
//  pix_y         out  COORD_W             pixel line
//  pix_color     out  24                  RGB888
//  pix_sof/eol/eof out 1 each             first pixel / last of line / last of frame
//  busy          out  1                   high in RUN
//  frame_done    out  1                   1-cycle pulse after final handshake
// BEHAVIOUR
//  Reset: state IDLE; pix_valid, busy, frame_done, sof/eol/eof = 0; pix_x, pix_y = 0; pix_color = 0.
//  FSM IDLE -> RUN on start; RUN -> IDLE on handshake of eof pixel. start in RUN is ignored.
//  On start edge: snapshot all object inputs and game_over; scan counters cleared. Mid-frame input changes do not affect the current frame.
//  Output register: loads next pixel when empty or when (pix_valid && pix_ready). First pix_valid one cycle after the start edge.
//  Throughput: 1 pixel/clk with ready held high; a frame is SCREEN_W*SCREEN_H handshakes.
//  Backpressure: while pix_valid && !pix_ready, all pix_* outputs hold stable.
//  Scan: x increments 0..SCREEN_W-1; x wraps to 0 with y+1. eol when x = SCREEN_W-1; eof when also y = SCREEN_H-1.
//  Screen y of object: sy = obj_y - min_y, modulo 2^COORD_W.
//  Hit test: bx <= x < bx+W and sy <= y < sy+H. Computed at COORD_W+1 bits so bx+W never wraps. Objects may clip at the right or bottom edge.
//  Priority: doodle > any active block > background. Background is GRAY e6e6c1, or RED ff0000 if game_over snapshot = 1. Block colour ff a0 0f; doodle colour 00ff00.
//  Inactive slots never hit. Overlapping blocks give the same colour.
//  frame_done is asserted the cycle after the eof handshake, with state already IDLE. A start in that same cycle is accepted.
//  Reset mid-frame aborts immediately to reset values; no frame_done.
// CONFIGURATION
//  RENDER_GRID_EN defined: background pixels with x%GRID_STEP==0 or y%GRID_STEP==0 are WHITE ffffff. Grid sits below blocks/doodle and is suppressed when game_over.
//    Implement with modulo counters, not dividers.
//  Not defined: plain background; grid logic absent.
// STRUCTURE
//  render_pkg holds:
//    - color_t (24b)
//    - colour constants WHITE/GRAY/GREEN/BROWN/RED
//    - state enum {IDLE, RUN}
//    - default COORD_W
//  Sub-module rect_hit_test (COORD_W, W, H): inputs px, py, rx, ry, min_y, en; output hit.
//    One instance per block slot, plus one for the doodle.
// TESTING
//  1. Reset, then start with no blocks and game_over=0 -> 280000 pixels, all e6e6c1. sof on (0,0); eof on (399,699); frame_done 1 cycle later.
//  2. Block slot 3 at (100,200), min_y=0 -> BROWN exactly on x 100..139, y 200..204. Pixels (99,200) and (140,204) are GRAY.
//  3. Doodle (120,198) overlaps the block, min_y=0 -> GREEN on x 120..127, y 198..205, taking priority over BROWN. Repeat with min_y=100 -> everything shifts up 100 lines.
//  4. Random pix_ready (50%) -> stream matches the ready=1 golden frame; outputs stable while stalled. Changing inputs mid-frame has no effect.
//  5. Block at (380,698) -> clipped to x 380..399, lines 698..699, no wrap. min_y > doodle_y -> doodle not drawn.
//  6. Reset at pixel 1000 -> pix_valid=0 next cycle, no frame_done. Next start gives a full clean frame. With RENDER_GRID_EN: (50,3) WHITE; (51,3) GRAY.

Source files
------------

// File: rtl/render_pkg.sv
// Shared colour, state and coordinate definitions for the raster frame renderer.
package render_pkg;

    localparam int DEFAULT_COORD_W = 16;

    typedef logic [23:0] color_t;

    localparam color_t WHITE = 24'hFFFFFF;
    localparam color_t GRAY  = 24'hE6E6C1;
    localparam color_t GREEN = 24'h00FF00;
    localparam color_t BROWN = 24'hFFA00F;
    localparam color_t RED   = 24'hFF0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rect_hit_test.sv
// Combinational point-in-rectangle test for one object, with the world y shifted into camera space.
module rect_hit_test #(
    parameter int COORD_W = 16,
    parameter int W       = 40,
    parameter int H       = 5
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] rx,
    input  logic [COORD_W-1:0] ry,
    input  logic [COORD_W-1:0] min_y,
    input  logic               en,
    output logic               hit
);

    localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(W);
    localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(H);

    logic [COORD_W-1:0] sy_s;
    logic [COORD_W:0]   px_s;
    logic [COORD_W:0]   py_s;
    logic [COORD_W:0]   x_lo_s;
    logic [COORD_W:0]   x_hi_s;
    logic [COORD_W:0]   y_lo_s;
    logic [COORD_W:0]   y_hi_s;

    // The extra top bit keeps the far edge from wrapping back onto the screen.
    assign sy_s   = ry - min_y;
    assign px_s   = {1'b0, px};
    assign py_s   = {1'b0, py};
    assign x_lo_s = {1'b0, rx};
    assign y_lo_s = {1'b0, sy_s};
    assign x_hi_s = x_lo_s + W_EXT;
    assign y_hi_s = y_lo_s + H_EXT;

    assign hit = en & (px_s >= x_lo_s) & (px_s < x_hi_s) & (py_s >= y_lo_s) & (py_s < y_hi_s);

endmodule

// File: rtl/raster_frame_renderer.sv
// Raster-order frame renderer: one RGB pixel per clock on a valid/ready stream, inputs snapshotted per frame.
// Optional background grid is enabled by defining RENDER_GRID_EN.
module raster_frame_renderer
    import render_pkg::*;
#(
    parameter int COORD_W    = DEFAULT_COORD_W,
    parameter int SCREEN_W   = 400,
    parameter int SCREEN_H   = 700,
    parameter int NUM_BLOCKS = 16,
    parameter int BLOCK_W    = 40,
    parameter int BLOCK_H    = 5,
    parameter int DOODLE_W   = 8,
    parameter int DOODLE_H   = 8,
    parameter int GRID_STEP  = 50
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          game_over,
    input  logic [COORD_W-1:0]            doodle_x,
    input  logic [COORD_W-1:0]            doodle_y,
    input  logic [COORD_W-1:0]            min_y,
    input  logic [NUM_BLOCKS*COORD_W-1:0] blocks_x,
    input  logic [NUM_BLOCKS*COORD_W-1:0] blocks_y,
    input  logic [NUM_BLOCKS-1:0]         block_active,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [COORD_W-1:0]            pix_x,
    output logic [COORD_W-1:0]            pix_y,
    output logic [23:0]                   pix_color,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          pix_eof,
    output logic                          busy,
    output logic                          frame_done
);

    localparam logic [COORD_W-1:0] ZERO   = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

    state_t state_r;
    state_t state_next_s;

    logic                          snap_go_r;
    logic [COORD_W-1:0]            snap_dx_r;
    logic [COORD_W-1:0]            snap_dy_r;
    logic [COORD_W-1:0]            snap_min_y_r;
    logic [NUM_BLOCKS*COORD_W-1:0] snap_bx_r;
    logic [NUM_BLOCKS*COORD_W-1:0] snap_by_r;
    logic [NUM_BLOCKS-1:0]         snap_act_r;

    logic                          eff_go_s;
    logic [COORD_W-1:0]            eff_dx_s;
    logic [COORD_W-1:0]            eff_dy_s;
    logic [COORD_W-1:0]            eff_min_y_s;
    logic [NUM_BLOCKS*COORD_W-1:0] eff_bx_s;
    logic [NUM_BLOCKS*COORD_W-1:0] eff_by_s;
    logic [NUM_BLOCKS-1:0]         eff_act_s;

    logic [COORD_W-1:0]    scan_x_r;
    logic [COORD_W-1:0]    scan_y_r;
    logic                  gen_done_r;
    logic                  start_s;
    logic                  accept_s;
    logic                  load_s;
    logic                  eof_hs_s;
    logic                  last_x_s;
    logic                  last_y_s;
    logic [NUM_BLOCKS-1:0] block_hit_s;
    logic                  doodle_hit_s;
    logic                  grid_s;
    color_t                color_s;

    assign start_s  = (state_r == IDLE) & start;
    assign accept_s = pix_valid & pix_ready;
    assign eof_hs_s = (state_r == RUN) & accept_s & pix_eof;
    assign load_s   = start_s | ((state_r == RUN) & ~gen_done_r & (~pix_valid | pix_ready));
    assign last_x_s = (scan_x_r == X_LAST);
    assign last_y_s = (scan_y_r == Y_LAST);

    // The first pixel is produced on the start edge itself, so it sees the live inputs being captured.
    always_comb begin
        eff_go_s    = snap_go_r;
        eff_dx_s    = snap_dx_r;
        eff_dy_s    = snap_dy_r;
        eff_min_y_s = snap_min_y_r;
        eff_bx_s    = snap_bx_r;
        eff_by_s    = snap_by_r;
        eff_act_s   = snap_act_r;
        if (state_r == IDLE) begin
            eff_go_s    = game_over;
            eff_dx_s    = doodle_x;
            eff_dy_s    = doodle_y;
            eff_min_y_s = min_y;
            eff_bx_s    = blocks_x;
            eff_by_s    = blocks_y;
            eff_act_s   = block_active;
        end else begin
            eff_go_s    = snap_go_r;
        end
    end

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_block
        rect_hit_test #(.COORD_W(COORD_W), .W(BLOCK_W), .H(BLOCK_H)) u_block_hit (
            .px    (scan_x_r),
            .py    (scan_y_r),
            .rx    (eff_bx_s[i*COORD_W +: COORD_W]),
            .ry    (eff_by_s[i*COORD_W +: COORD_W]),
            .min_y (eff_min_y_s),
            .en    (eff_act_s[i]),
            .hit   (block_hit_s[i])
        );
    end

    rect_hit_test #(.COORD_W(COORD_W), .W(DOODLE_W), .H(DOODLE_H)) u_doodle_hit (
        .px    (scan_x_r),
        .py    (scan_y_r),
        .rx    (eff_dx_s),
        .ry    (eff_dy_s),
        .min_y (eff_min_y_s),
        .en    (1'b1),
        .hit   (doodle_hit_s)
    );

`ifdef RENDER_GRID_EN
    logic [COORD_W-1:0] grid_x_r;
    logic [COORD_W-1:0] grid_y_r;

    assign grid_s = (grid_x_r == ZERO) | (grid_y_r == ZERO);

    // Modulo-GRID_STEP shadows of the scan counters; both return to zero at end of frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            grid_x_r <= ZERO;
            grid_y_r <= ZERO;
        end else if (load_s) begin
            if (last_x_s) begin
                grid_x_r <= ZERO;
                if (last_y_s || (grid_y_r == COORD_W'(GRID_STEP - 1))) begin
                    grid_y_r <= ZERO;
                end else begin
                    grid_y_r <= grid_y_r + ONE;
                end
            end else if (grid_x_r == COORD_W'(GRID_STEP - 1)) begin
                grid_x_r <= ZERO;
            end else begin
                grid_x_r <= grid_x_r + ONE;
            end
        end else begin
            grid_x_r <= grid_x_r;
        end
    end
`else
    assign grid_s = 1'b0;
`endif

    // Pixel colour by priority: doodle, block, background.
    always_comb begin
        color_s = GRAY;
        if (doodle_hit_s) begin
            color_s = GREEN;
        end else if (|block_hit_s) begin
            color_s = BROWN;
        end else if (eff_go_s) begin
            color_s = RED;
        end else if (grid_s) begin
            color_s = WHITE;
        end else begin
            color_s = GRAY;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (eof_hs_s) state_next_s = IDLE;
                else          state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Snapshot, scan counters and the output pixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_go_r    <= 1'b0;
            snap_dx_r    <= ZERO;
            snap_dy_r    <= ZERO;
            snap_min_y_r <= ZERO;
            snap_bx_r    <= {(NUM_BLOCKS*COORD_W){1'b0}};
            snap_by_r    <= {(NUM_BLOCKS*COORD_W){1'b0}};
            snap_act_r   <= {NUM_BLOCKS{1'b0}};
            scan_x_r     <= ZERO;
            scan_y_r     <= ZERO;
            gen_done_r   <= 1'b0;
            pix_valid    <= 1'b0;
            pix_x        <= ZERO;
            pix_y        <= ZERO;
            pix_color    <= 24'h000000;
            pix_sof      <= 1'b0;
            pix_eol      <= 1'b0;
            pix_eof      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= eof_hs_s;
            busy       <= (state_next_s == RUN);
            if (start_s) begin
                snap_go_r    <= game_over;
                snap_dx_r    <= doodle_x;
                snap_dy_r    <= doodle_y;
                snap_min_y_r <= min_y;
                snap_bx_r    <= blocks_x;
                snap_by_r    <= blocks_y;
                snap_act_r   <= block_active;
            end
            if (load_s) begin
                pix_valid  <= 1'b1;
                pix_x      <= scan_x_r;
                pix_y      <= scan_y_r;
                pix_color  <= color_s;
                pix_sof    <= (scan_x_r == ZERO) & (scan_y_r == ZERO);
                pix_eol    <= last_x_s;
                pix_eof    <= last_x_s & last_y_s;
                gen_done_r <= last_x_s & last_y_s;
                if (last_x_s) begin
                    scan_x_r <= ZERO;
                    scan_y_r <= last_y_s ? ZERO : (scan_y_r + ONE);
                end else begin
                    scan_x_r <= scan_x_r + ONE;
                end
            end else if (accept_s) begin
                pix_valid <= 1'b0;
                pix_sof   <= 1'b0;
                pix_eol   <= 1'b0;
                pix_eof   <= 1'b0;
            end else begin
                pix_valid <= pix_valid;
            end
        end
    end

endmodule
